// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder: instruction/data memory responder beside the CPU control unit, with a host loader port
// Ports: clk/rst (sync, active-high); progcntr/fetch -> inst; D_addr/D_rd/D_wr/D_W_data -> D_R_data;
//        loader ld_req/ld_valid/ld_ready/ld_sel/ld_addr/ld_data/ld_done; cpu_hold holds the CPU in reset;
//        fetch_err is a sticky out-of-range fetch flag, active only when IMEM_OOR_TRAP_EN is defined.
module cpu_mem_responder #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int I_WIDTH    = 16,
  parameter int D_WIDTH    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        progcntr,
  input  logic               fetch,
  output logic [I_WIDTH-1:0] inst,
  input  logic [7:0]         D_addr,
  input  logic               D_rd,
  input  logic               D_wr,
  input  logic [D_WIDTH-1:0] D_W_data,
  output logic [D_WIDTH-1:0] D_R_data,
  input  logic               ld_req,
  input  logic               ld_valid,
  output logic               ld_ready,
  input  logic               ld_sel,
  input  logic [15:0]        ld_addr,
  input  logic [I_WIDTH-1:0] ld_data,
  input  logic               ld_done,
  output logic               cpu_hold,
  output logic               fetch_err
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  typedef enum logic [1:0] {LOAD, DRAIN, RUN} state_t;
  state_t state, state_next;
  logic [I_WIDTH-1:0] imem [IMEM_DEPTH];
  logic [D_WIDTH-1:0] dmem [DMEM_DEPTH];
  logic run, ld_wr, i_oor, imem_we, dmem_we;
  logic [DAW-1:0] dmem_wa;
  logic [D_WIDTH-1:0] dmem_wd;
  logic unused_bits;
  assign unused_bits = ^{progcntr, D_addr, ld_addr};
  always_comb begin
    state_next = state == LOAD  ? (ld_done ? DRAIN : LOAD) :
                 state == DRAIN ? RUN : (ld_req ? LOAD : RUN);
    ld_ready = state == LOAD;
    cpu_hold = state != RUN;
  end
  always_ff @(posedge clk)
    if (rst) state <= LOAD;
    else state <= state_next;
  assign run   = state == RUN;
  assign ld_wr = ld_valid & ld_ready;
  // Out-of-range loader addresses still complete the handshake; only the write is dropped.
  assign imem_we = ld_wr & ~ld_sel & (32'(ld_addr) < IMEM_DEPTH);
  // Loader and CPU never write dmem in the same state, so one shared write port suffices.
  assign dmem_we = run ? D_wr : ld_wr & ld_sel & (32'(ld_addr) < DMEM_DEPTH);
  assign dmem_wa = run ? D_addr[DAW-1:0] : ld_addr[DAW-1:0];
  assign dmem_wd = run ? D_W_data : ld_data[D_WIDTH-1:0];
  always_ff @(posedge clk) begin
    if (!rst && imem_we) imem[ld_addr[IAW-1:0]] <= ld_data;
    if (!rst && dmem_we) dmem[dmem_wa] <= dmem_wd;
  end
`ifdef IMEM_OOR_TRAP_EN
  assign i_oor = 32'(progcntr) >= IMEM_DEPTH;
  always_ff @(posedge clk)
    if (rst || (run && ld_req)) fetch_err <= 1'b0;
    else if (run && fetch && i_oor) fetch_err <= 1'b1;
`else
  assign i_oor = 1'b0;
  assign fetch_err = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      inst     <= '0;
      D_R_data <= '0;
    end else begin
      if (run && fetch) inst <= i_oor ? '0 : imem[progcntr[IAW-1:0]];
      if (run && D_rd) D_R_data <= dmem[D_addr[DAW-1:0]];
    end
endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb_cpu_mem_responder: directed self-checking bench for cpu_mem_responder
module tb_cpu_mem_responder;
  logic clk = 0, rst, fetch, D_rd, D_wr, ld_req, ld_valid, ld_sel, ld_done;
  logic [15:0] progcntr, ld_addr, ld_data, inst;
  logic [7:0] D_addr, D_W_data, D_R_data;
  logic ld_ready, cpu_hold, fetch_err;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  cpu_mem_responder dut (
    .clk(clk), .rst(rst), .progcntr(progcntr), .fetch(fetch), .inst(inst),
    .D_addr(D_addr), .D_rd(D_rd), .D_wr(D_wr), .D_W_data(D_W_data), .D_R_data(D_R_data),
    .ld_req(ld_req), .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_sel(ld_sel),
    .ld_addr(ld_addr), .ld_data(ld_data), .ld_done(ld_done), .cpu_hold(cpu_hold),
    .fetch_err(fetch_err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic load(input logic sel, input logic [15:0] a, input logic [15:0] d);
    ld_valid = 1; ld_sel = sel; ld_addr = a; ld_data = d;
    tick;
    ld_valid = 0;
  endtask
  initial begin
    rst = 1; fetch = 0; D_rd = 0; D_wr = 0; ld_req = 0; ld_valid = 0; ld_sel = 0; ld_done = 0;
    progcntr = 0; ld_addr = 0; ld_data = 0; D_addr = 0; D_W_data = 0;
    tick; tick;
    rst = 0;
    check("rst_hold", cpu_hold, 1);
    check("rst_ready", ld_ready, 1);
    check("rst_inst", inst, 0);
    check("rst_rdata", D_R_data, 0);
    check("rst_ferr", fetch_err, 0);
    load(0, 16'h0000, 16'h1105);
    load(0, 16'h0001, 16'h2206);
    load(0, 16'h0002, 16'h0000);
    load(0, 16'h0100, 16'hBEEF);
    load(1, 16'h0020, 16'h0077);
    check("load_ready", ld_ready, 1);
    ld_done = 1;
    tick;
    ld_done = 0;
    check("drain_hold", cpu_hold, 1);
    check("drain_ready", ld_ready, 0);
    tick;
    check("run_hold", cpu_hold, 0);
    check("run_ready", ld_ready, 0);
    ld_valid = 1; ld_sel = 0; ld_addr = 0; ld_data = 16'hDEAD;
    fetch = 1; progcntr = 1;
    tick;
    ld_valid = 0;
    check("fetch1", inst, 16'h2206);
    fetch = 0; progcntr = 0;
    tick;
    check("fetch_hold", inst, 16'h2206);
    fetch = 1;
    tick;
    fetch = 0;
    check("fetch0_no_run_ld", inst, 16'h1105);
    D_wr = 1; D_addr = 8'h10; D_W_data = 8'hA5;
    tick;
    D_wr = 0; D_rd = 1;
    tick;
    check("rd_a5", D_R_data, 8'hA5);
    D_wr = 1; D_W_data = 8'h3C;
    tick;
    D_wr = 0;
    check("rw_read_first", D_R_data, 8'hA5);
    tick;
    check("rd_3c", D_R_data, 8'h3C);
    D_addr = 8'h20;
    tick;
    D_rd = 0;
    check("rd_loaded", D_R_data, 8'h77);
    fetch = 1; progcntr = 16'h0100;
    tick;
`ifdef IMEM_OOR_TRAP_EN
    check("oor_inst", inst, 0);
    check("oor_err", fetch_err, 1);
`else
    check("oor_wrap_inst", inst, 16'h1105);
    check("oor_err", fetch_err, 0);
`endif
    progcntr = 1;
    tick;
    fetch = 0;
    check("post_oor_inst", inst, 16'h2206);
`ifdef IMEM_OOR_TRAP_EN
    check("err_sticky", fetch_err, 1);
`else
    check("err_sticky", fetch_err, 0);
`endif
    ld_req = 1;
    tick;
    ld_req = 0;
    check("req_hold", cpu_hold, 1);
    check("req_ready", ld_ready, 1);
    check("req_ferr_clr", fetch_err, 0);
    fetch = 1; progcntr = 0; D_wr = 1; D_rd = 1; D_addr = 8'h20; D_W_data = 8'h55;
    tick;
    fetch = 0; D_wr = 0; D_rd = 0;
    check("load_fetch_ign", inst, 16'h2206);
    check("load_rd_ign", D_R_data, 8'h77);
    ld_valid = 1; ld_sel = 1; ld_addr = 16'h0021; ld_data = 16'h005A; ld_done = 1;
    tick;
    ld_valid = 0; ld_done = 0;
    check("done_drain", ld_ready, 0);
    tick;
    check("run2_hold", cpu_hold, 0);
    D_rd = 1; D_addr = 8'h20;
    tick;
    check("load_wr_ign", D_R_data, 8'h77);
    D_addr = 8'h21;
    tick;
    D_rd = 0;
    check("done_same_wr", D_R_data, 8'h5A);
    D_wr = 1; D_addr = 8'h30; D_W_data = 8'h99; fetch = 1; progcntr = 1; rst = 1;
    tick;
    rst = 0; D_wr = 0; fetch = 0;
    check("rst6_hold", cpu_hold, 1);
    check("rst6_ready", ld_ready, 1);
    check("rst6_inst", inst, 0);
    check("rst6_rdata", D_R_data, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
